// File: rtl/uart_receiver.sv
// uart_receiver - 16x oversampled UART receiver, 8 data bits, LSB first, 1 stop bit.
//
// Parameters:
//   CLK_FREQ  sysclk frequency in Hz
//   BAUD      line rate in bit/s
//   (DIV = CLK_FREQ / (BAUD*16) is derived and must be >= 2)
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   UART_RX    in   asynchronous serial line, idles high
//   RX_DATA    out  last correctly framed byte, held until the next good frame
//   RX_STATUS  out  one-cycle strobe when RX_DATA is updated
//   RX_ERR     out  one-cycle strobe when a frame is rejected
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frame, a PARITY state samples one even-parity bit; a parity
//                or stop failure gives RX_ERR at the stop sample
//   undefined -> 8N1 frame, RX_ERR reports stop-bit failure only
module uart_receiver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR
);

    localparam int            DIV      = CLK_FREQ / (BAUD * 16);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    logic [1:0]    sync_r;
    logic          rx_s;
    logic [CW-1:0] div_cnt_r;
    logic [3:0]    samp_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tick_s;
    logic          sample_s;
    logic          good_s;
    logic          bad_s;
    logic          par_err_s;
    state_t        state_r;
    state_t        state_nx_s;

    assign rx_s     = sync_r[1];
    assign tick_s   = (div_cnt_r == DIV_LAST);
    // Counter value 7 on a tick is the 8th tick of the bit, i.e. mid-bit.
    assign sample_s = tick_s && (samp_cnt_r == 4'd7);

`ifdef UART_RX_PARITY_EN
    // Even parity: the XOR over data and parity bit must be zero.
    function automatic logic even_par_err(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic par_err_r;

    // Parity error flag: cleared per frame, captured at the parity sample.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            par_err_r <= 1'b0;
        end else if (state_r == ST_START) begin
            par_err_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && sample_s) begin
            par_err_r <= even_par_err(shift_r, rx_s);
        end
    end

    assign par_err_s = par_err_r;
`else
    assign par_err_s = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], UART_RX};
        end
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and frame verdict at the stop-bit sample.
    always_comb begin
        state_nx_s = state_r;
        good_s     = 1'b0;
        bad_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    if (rx_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nx_s = ST_PARITY;
`else
                    state_nx_s = ST_STOP;
`endif
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_s) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (sample_s) begin
                    // Return to IDLE right away so a start edge that follows
                    // the stop bit immediately is still caught.
                    state_nx_s = ST_IDLE;
                    if (rx_s && !par_err_s) begin
                        good_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Tick and sample counters; held at zero in IDLE so they restart with the start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= 4'd0;
        end else if (tick_s) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= samp_cnt_r + 4'd1;
        end else begin
            div_cnt_r  <= div_cnt_r + CW'(1);
        end
    end

    // Data shift register and bit index.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else if ((state_r == ST_START) && sample_s) begin
            bit_idx_r <= 3'd0;
        end else if ((state_r == ST_DATA) && sample_s) begin
            shift_r[bit_idx_r] <= rx_s;
            bit_idx_r          <= bit_idx_r + 3'd1;
        end
    end

    // Registered outputs: byte capture and one-cycle strobes.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            RX_DATA   <= 8'h00;
            RX_STATUS <= 1'b0;
            RX_ERR    <= 1'b0;
        end else begin
            RX_STATUS <= good_s;
            RX_ERR    <= bad_s;
            if (good_s) begin
                RX_DATA <= shift_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BIT_CYC = 160;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 1523 + 160;
`else
    localparam int LAT_NOM = 1523;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_ERR;

    int  checks_cnt = 0;
    int  errors_cnt = 0;
    int  status_cnt = 0;
    int  err_cnt    = 0;
    int  both_cnt   = 0;
    int  wide_cnt   = 0;
    logic prev_status = 1'b0;
    logic prev_err    = 1'b0;
    time last_status_t = 0;
    time t_fall = 0;

    uart_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .UART_RX  (UART_RX),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .RX_ERR   (RX_ERR)
    );

    always #5 sysclk = ~sysclk;

    // Strobe monitor sampled on the falling edge.
    always @(negedge sysclk) begin
        if (RX_STATUS) begin
            status_cnt    <= status_cnt + 1;
            last_status_t <= $time;
        end
        if (RX_ERR) err_cnt <= err_cnt + 1;
        if (RX_STATUS && RX_ERR) both_cnt <= both_cnt + 1;
        if ((RX_STATUS && prev_status) || (RX_ERR && prev_err)) wide_cnt <= wide_cnt + 1;
        prev_status <= RX_STATUS;
        prev_err    <= RX_ERR;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        UART_RX = b;
        repeat (BIT_CYC) @(negedge sysclk);
    endtask

    task automatic idle_bits(input int n);
        UART_RX = 1'b1;
        repeat (n * BIT_CYC) @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic pb;
        pb = (^d) ^ par_flip;
        t_fall = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pb);
`endif
        drive_bit(stop_b);
    endtask

    initial begin
        int s0, e0;
        time t_first;
        int lat;
        int gap;
        logic [7:0] d3c;

        UART_RX = 1'b1;
        reset   = 1'b1;
        repeat (5) @(negedge sysclk);
        check_value("rst_data",   32'(RX_DATA),   32'h00);
        check_value("rst_status", 32'(RX_STATUS), 32'h0);
        check_value("rst_err",    32'(RX_ERR),    32'h0);
        reset = 1'b0;
        idle_bits(1);

        // 1: two good frames
        s0 = status_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        check_value("t1_data55",   32'(RX_DATA), 32'h55);
        check_value("t1_status55", 32'(status_cnt - s0), 32'd1);
        check_value("t1_noerr",    32'(err_cnt - e0), 32'd0);
        lat = int'((last_status_t - t_fall) / 10);
        check_value("t1_latency_window", 32'((lat >= LAT_NOM - 3) && (lat <= LAT_NOM + 3)), 32'd1);
        idle_bits(1);
        send_frame(8'hA3, 1'b1, 1'b0);
        check_value("t1_dataA3",   32'(RX_DATA), 32'hA3);
        check_value("t1_statusA3", 32'(status_cnt - s0), 32'd2);
        idle_bits(1);

        // 2: 40-cycle glitch is a false start
        s0 = status_cnt; e0 = err_cnt;
        UART_RX = 1'b0;
        repeat (40) @(negedge sysclk);
        idle_bits(3);
        check_value("t2_nostatus", 32'(status_cnt - s0), 32'd0);
        check_value("t2_noerr",    32'(err_cnt - e0), 32'd0);
        check_value("t2_data_held", 32'(RX_DATA), 32'hA3);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_value("t2_after_idle", 32'(RX_DATA), 32'h5A);
        idle_bits(1);

        // 3: bad stop bit after a good byte
        send_frame(8'h12, 1'b1, 1'b0);
        idle_bits(1);
        s0 = status_cnt; e0 = err_cnt;
        send_frame(8'hC4, 1'b0, 1'b0);
        idle_bits(3);
        check_value("t3_err_once",  32'(err_cnt - e0), 32'd1);
        check_value("t3_nostatus",  32'(status_cnt - s0), 32'd0);
        check_value("t3_data_kept", 32'(RX_DATA), 32'h12);

        // 4: back-to-back frames, no idle between
        s0 = status_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        check_value("t4_data00", 32'(RX_DATA), 32'h00);
        t_first = last_status_t;
        send_frame(8'hFF, 1'b1, 1'b0);
        check_value("t4_dataFF",  32'(RX_DATA), 32'hFF);
        check_value("t4_two_strobes", 32'(status_cnt - s0), 32'd2);
        gap = int'((last_status_t - t_first) / 10);
`ifdef UART_RX_PARITY_EN
        check_value("t4_gap_window", 32'((gap >= 1755) && (gap <= 1765)), 32'd1);
`else
        check_value("t4_gap_window", 32'((gap >= 1595) && (gap <= 1605)), 32'd1);
`endif
        idle_bits(1);

        // 5: reset during data bit 4 of 0x3C, then a clean 0x81
        s0 = status_cnt; e0 = err_cnt;
        d3c = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d3c[i]);
        UART_RX = d3c[4];
        repeat (80) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        check_value("t5_rst_data",   32'(RX_DATA),   32'h00);
        check_value("t5_rst_status", 32'(RX_STATUS), 32'h0);
        check_value("t5_rst_err",    32'(RX_ERR),    32'h0);
        reset = 1'b0;
        idle_bits(3);
        check_value("t5_no_strobe",  32'((status_cnt - s0) + (err_cnt - e0)), 32'd0);
        check_value("t5_data_zero",  32'(RX_DATA), 32'h00);
        send_frame(8'h81, 1'b1, 1'b0);
        check_value("t5_data81", 32'(RX_DATA), 32'h81);
        idle_bits(1);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then parity bad
        s0 = status_cnt; e0 = err_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        check_value("t6_par_ok_data",   32'(RX_DATA), 32'h07);
        check_value("t6_par_ok_status", 32'(status_cnt - s0), 32'd1);
        idle_bits(1);
        s0 = status_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        check_value("t6_par_bad_err",    32'(err_cnt - e0), 32'd1);
        check_value("t6_par_bad_status", 32'(status_cnt - s0), 32'd0);
        check_value("t6_par_bad_data",   32'(RX_DATA), 32'h07);
`endif

        check_value("never_both",   32'(both_cnt), 32'd0);
        check_value("width_one",    32'(wide_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
